// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32 data memory: FUNC3 access codes and FSM states.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane formatting for loads and stores: enables, shifted store data,
// extracted/extended load data and misalignment detection.
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    always_comb begin
        shamt      = {addr_lo, 3'b000};
        shifted    = mem_word >> shamt;
        store_word = store_data << shamt;
        byte_en    = 4'b1111;
        load_data  = mem_word;
        misaligned = 1'b0;
        case (func3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                load_data = (func3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                            : {24'h0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                misaligned = addr_lo[0];
                byte_en    = 4'b0011 << addr_lo;
                load_data  = (func3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
            end
            // Word access; unused codes fall here too.
            default: misaligned = (addr_lo != 2'b00);
        endcase
        if (misaligned) begin
            byte_en   = 4'b0000;
            load_data = 32'h0;
        end
    end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory: IDLE/WAIT/DONE handshake with BUSYWAIT stall,
// byte-enabled word storage and formatted, registered load data.
module data_memory
    import rv32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] MEM_ADDRESS,
    input  logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT,
    output logic        MISALIGNED
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    mem_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wr_q, wr_d, rd_q, rd_d;
    logic [2:0]     func3_q, func3_d;
    logic [AW+1:0]  addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           mis_q, mis_d;

    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  widx;
    logic [31:0]    mem_word, store_word, load_data;
    logic [3:0]     byte_en;
    logic           lane_mis, mem_we, busy;
    logic           unused_addr_hi;

    // Address bits above the word index are ignored so accesses wrap.
    assign unused_addr_hi = ^MEM_ADDRESS[31:AW+2];
    assign widx           = addr_q[AW+1:2];
    assign mem_word       = mem[widx];

    mem_lane_align u_align (
        .func3      (func3_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (wdata_q),
        .mem_word   (mem_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .misaligned (lane_mis)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        func3_d = func3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        busy    = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (MEM_READ || MEM_WRITE) begin
                    busy    = 1'b1;
                    wr_d    = MEM_WRITE;
                    rd_d    = MEM_READ && !MEM_WRITE;
                    func3_d = FUNC3;
                    addr_d  = MEM_ADDRESS[AW+1:0];
                    wdata_d = MEM_WRITE_DATA;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    mem_we  = wr_q && !lane_mis;
                    mis_d   = lane_mis;
                    if (rd_q) rdata_d = load_data;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                mis_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            func3_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            func3_q <= func3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[widx][8*b +: 8] <= store_word[8*b +: 8];
            end
        end
    end

    assign BUSYWAIT   = busy && RESET;
    assign READ_DATA  = rdata_q;
    assign MISALIGNED = mis_q;

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored; power of two.
REQ-002 Parameter LATENCY, default 3, number of WAIT cycles per access; minimum 1.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 MEM_READ  input  1  load request from the EX/MEM stage.
REQ-006 MEM_WRITE  input  1  store request from the EX/MEM stage.
REQ-007 FUNC3  input  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-008 MEM_ADDRESS  input  32  byte address.
REQ-009 MEM_WRITE_DATA  input  32  store data, right-aligned.
REQ-010 READ_DATA  output  32  formatted load result, right-aligned.
REQ-011 BUSYWAIT  output  1  stall request to all pipeline registers.
REQ-012 MISALIGNED  output  1  one-cycle flag: the last access was misaligned and was dropped.

Function
REQ-013 The FSM SHALL have three states, IDLE, WAIT and DONE, with a counter of width clog2(LATENCY+1).
REQ-014 BUSYWAIT SHALL be asserted combinationally in IDLE when MEM_READ or MEM_WRITE is high, and SHALL be high throughout WAIT and low in DONE.
REQ-015 On the IDLE-state request edge, the block SHALL do all of the following:
- latch op, FUNC3, MEM_ADDRESS and MEM_WRITE_DATA;
- load the counter with LATENCY-1;
- enter WAIT.
REQ-016 In WAIT, the counter SHALL decrement each edge; at the edge where it equals 0, the access SHALL execute and the FSM SHALL enter DONE.
REQ-017 Total request-to-release latency SHALL be LATENCY+1 cycles of BUSYWAIT high, followed by exactly one DONE cycle.
REQ-018 In DONE, requests SHALL be ignored; the next edge SHALL return the FSM to IDLE. A request still present in IDLE SHALL start a new access.
REQ-019 Loads SHALL select lanes by address[1:0] and extend per FUNC3:
- LB/LH sign-extend;
- LBU/LHU zero-extend;
- LW takes all 32 bits.
REQ-020 Stores SHALL update only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes); other bytes of the word SHALL be unchanged.
REQ-021 READ_DATA SHALL hold its value from the executing edge until the next load executes; stores SHALL not change READ_DATA.
REQ-022 The word index SHALL be address[clog2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so accesses wrap.
REQ-023 A halfword access with address[0]=1, or a word access with address[1:0]!=0, SHALL be handled as follows:
- no storage update;
- READ_DATA set to 0 for loads;
- MISALIGNED high during DONE only;
- the full latency still taken.
REQ-024 If MEM_READ and MEM_WRITE are both high at the request edge, the write SHALL take precedence and READ_DATA SHALL be unchanged.
REQ-025 Unused FUNC3 codes (011, 110, 111) SHALL be treated as LW/SW.

Reset
REQ-026 While RESET is low, the following SHALL hold:
- FSM in IDLE, counter 0;
- READ_DATA 0, MISALIGNED 0;
- BUSYWAIT 0 regardless of request inputs.
REQ-027 A reset asserted in WAIT SHALL abort the access: no storage update, and no DONE cycle afterwards.
REQ-028 Storage contents SHALL NOT be reset.

Structure
REQ-029 A shared package rv32_mem_pkg SHALL hold the FUNC3 load/store constants and the IDLE/WAIT/DONE state enum.
REQ-030 Lane formatting SHALL live in one combinational sub-module, mem_lane_align, which produces:
- store byte-enables and shifted store data;
- load extraction and extension;
- the misalignment flag.
REQ-031 Storage SHALL be a single DEPTH_WORDS x 32 array written with per-byte enables.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 -> BUSYWAIT high 4 cycles (LATENCY=3) for each access, READ_DATA=0xDEADBEEF in DONE.
REQ-033 After REQ-032, the following loads SHALL return:
- LB @0x13 -> 0xFFFFFFDE;
- LBU @0x13 -> 0x000000DE;
- LH @0x10 -> 0xFFFFBEEF;
- LHU @0x12 -> 0x0000DEAD.
REQ-034 SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF; SH 0x1234 @0x12 then LW @0x10 -> 0x123455EF.
REQ-035 LW @0x12 -> MISALIGNED=1 in DONE only, READ_DATA=0; a following LW @0x10 returns unchanged contents.
REQ-036 SW 0xA5A5A5A5 @0x20, RESET low during the 2nd WAIT cycle -> BUSYWAIT drops immediately, no DONE cycle; a later LW @0x20 returns the old value.
REQ-037 SW 0x11111111 @(DEPTH_WORDS*4) then LW @0x0 -> 0x11111111 (wrap); MEM_READ and MEM_WRITE both high -> store performed, READ_DATA unchanged.
